// File: rtl/piso_readout.sv
// piso_readout: parallel-in, serial-out readout shifter for one SRAM row word.
// A COLS-bit word is captured via valid/ready, then streamed MSB-first with one
// bit accepted per downstream shift strobe. A one-cycle done pulse closes a frame.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_readout #(
   parameter int unsigned COLS = 16
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [COLS-1:0] parallel_in,
   input  logic            abort,
   input  logic            shift,
   output logic            serial_out,
   output logic            serial_valid,
   output logic            busy,
   output logic            done
);

`ifdef PISO_PARITY_EN
   // Counter reaches COLS+1 after the parity bit, so it needs one more code point.
   localparam int unsigned CNT_W     = $clog2(COLS + 2);
   localparam int unsigned FrameBits = COLS + 1;
`else
   localparam int unsigned CNT_W     = $clog2(COLS + 1);
   localparam int unsigned FrameBits = COLS;
`endif

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FrameBits - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [COLS-1:0] shift_reg_q, shift_reg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] ParCnt = CNT_W'(COLS);
   logic par_q, par_d;
`endif

   // Next-state logic; abort overrides capture and shift in every state.
   always_comb begin
      state_d     = state_q;
      shift_reg_d = shift_reg_q;
      bit_cnt_d   = bit_cnt_q;
`ifdef PISO_PARITY_EN
      par_d       = par_q;
`endif
      if (abort) begin
         state_d     = StIdle;
         bit_cnt_d   = '0;
         shift_reg_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  shift_reg_d = parallel_in;
                  bit_cnt_d   = '0;
                  state_d     = StShift;
`ifdef PISO_PARITY_EN
                  par_d       = ^parallel_in;
`endif
               end
            end
            StShift: begin
               if (shift) begin
                  shift_reg_d = {shift_reg_q[COLS-2:0], 1'b0};
                  bit_cnt_d   = bit_cnt_q + CntOne;
                  if (bit_cnt_q == LastCnt) begin
                     state_d = StDone;
                  end
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= StIdle;
         shift_reg_q <= '0;
         bit_cnt_q   <= '0;
`ifdef PISO_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_reg_q <= shift_reg_d;
         bit_cnt_q   <= bit_cnt_d;
`ifdef PISO_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   // Outputs decode from registered state only; no input reaches an output.
   always_comb begin
      in_ready     = 1'b0;
      serial_valid = 1'b0;
      serial_out   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
         end
         StShift: begin
            serial_valid = 1'b1;
            busy         = 1'b1;
`ifdef PISO_PARITY_EN
            serial_out   = (bit_cnt_q == ParCnt) ? par_q : shift_reg_q[COLS-1];
`else
            serial_out   = shift_reg_q[COLS-1];
`endif
         end
         StDone: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_readout.sv
// Bench for piso_readout: stimulus pushes expected serial bits and frame
// records into queues; a negedge monitor checks every presented/accepted bit,
// reconstructs the word like an LSB-in receiver, and checks it on done.
module tb_piso_readout;

   localparam int unsigned COLS = 16;
`ifdef PISO_PARITY_EN
   localparam int unsigned FB = COLS + 1;
`else
   localparam int unsigned FB = COLS;
`endif

   logic            clk = 1'b0;
   logic            arst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [COLS-1:0] parallel_in = '0;
   logic            abort = 1'b0;
   logic            shift = 1'b0;
   logic            serial_out;
   logic            serial_valid;
   logic            busy;
   logic            done;

   piso_readout #(.COLS(COLS)) dut (
      .clk          (clk),
      .arst         (arst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .parallel_in  (parallel_in),
      .abort        (abort),
      .shift        (shift),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           len;
      logic [COLS:0] word;
   } frame_t;

   logic   exp_bits[$];
   frame_t exp_frames[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   logic [COLS:0] rx = '0;
   int            rx_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Push the first nbits of a frame; a full frame also gets a done record.
   task automatic push_frame(input logic [COLS-1:0] w, input int nbits);
      logic [COLS:0] full;
      frame_t f;
`ifdef PISO_PARITY_EN
      full = {w, ^w};
`else
      full = {1'b0, w};
`endif
      for (int i = 0; i < nbits; i++) exp_bits.push_back(full[FB-1-i]);
      if (nbits == FB) begin
         f.len  = FB;
         f.word = full;
         exp_frames.push_back(f);
      end
   endtask

   // Monitor: checks each presented bit, pops on acceptance, checks frames on done.
   always @(negedge clk) begin
      frame_t f;
      if (arst) begin
         rx     = '0;
         rx_cnt = 0;
      end else begin
         if (serial_valid && !abort) begin
            if (exp_bits.size() == 0) fail_now("unexpected_serial_bit");
            else check("serial_out", serial_out, exp_bits[0]);
         end
         if (abort) begin
            rx     = '0;
            rx_cnt = 0;
         end else if (serial_valid && shift && exp_bits.size() > 0) begin
            void'(exp_bits.pop_front());
            rx = {rx[COLS-1:0], serial_out};
            rx_cnt++;
         end
         if (done) begin
            if (exp_frames.size() == 0) fail_now("unexpected_done");
            else begin
               f = exp_frames.pop_front();
               check("frame_len", rx_cnt, f.len);
               check("frame_word", rx, f.word);
            end
            rx     = '0;
            rx_cnt = 0;
         end
      end
   end

   task automatic wait_ready(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) fail_now("wait_ready_timeout");
   endtask

   // Handshake at the next edge; returns 1 time unit into cycle 1.
   task automatic send_word(input logic [COLS-1:0] w, input logic sh);
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      parallel_in = w;
      shift       = sh;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // Reset values while arst is held.
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_serial_valid", serial_valid, 0);
      check("rst_serial_out", serial_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #2 arst = 1'b0;

      // Word A5C3 with shift held high: exact cycle timing of done and in_ready.
      push_frame(16'hA5C3, FB);
      send_word(16'hA5C3, 1'b1);
      for (int c = 1; c <= FB + 2; c++) begin
         @(negedge clk);
         check("t1_done", done, (c == FB + 1) ? 1 : 0);
         check("t1_in_ready", in_ready, (c == FB + 2) ? 1 : 0);
         check("t1_busy", busy, (c <= FB + 1) ? 1 : 0);
         check("t1_serial_valid", serial_valid, (c <= FB) ? 1 : 0);
         @(posedge clk);
         #1;
      end
      shift = 1'b0;

      // Same word, shift only every third cycle; serial_valid must stay high.
      wait_ready(10);
      push_frame(16'hA5C3, FB);
      send_word(16'hA5C3, 1'b0);
      k = 1;
      forever begin
         shift = (k % 3 == 0);
         @(negedge clk);
         if (done) break;
         check("t2_serial_valid", serial_valid, 1);
         if (k > 3 * FB + 10) begin
            fail_now("t2_done_timeout");
            break;
         end
         @(posedge clk);
         #1;
         k++;
      end
      shift = 1'b0;

      // in_valid with FFFF held during a frame of 0000 must not be captured.
      wait_ready(10);
      push_frame(16'h0000, FB);
      send_word(16'h0000, 1'b1);
      in_valid    = 1'b1;
      parallel_in = 16'hFFFF;
      k = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         check("t3_in_ready", in_ready, 0);
         k++;
         if (k > FB + 5) begin
            fail_now("t3_done_timeout");
            break;
         end
      end
      in_valid = 1'b0;
      shift    = 1'b0;
      @(negedge clk);
      check("t3_idle_in_ready", in_ready, 1);
      @(negedge clk);
      check("t3_no_capture", serial_valid, 0);

      // Abort after 5 accepted bits, asserted alongside shift.
      wait_ready(10);
      push_frame(16'hA5C3, 5);
      send_word(16'hA5C3, 1'b1);
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      shift = 1'b0;
      @(negedge clk);
      check("t4_serial_valid", serial_valid, 0);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      check("t4_in_ready", in_ready, 1);
      push_frame(16'h8001, FB);
      send_word(16'h8001, 1'b1);
      wait_ready(FB + 10);
      shift = 1'b0;

      // Async reset mid-frame after 9 accepted bits.
      push_frame(16'hA5C3, 9);
      send_word(16'hA5C3, 1'b1);
      repeat (9) @(posedge clk);
      #1 shift = 1'b0;
      #1 arst = 1'b1;
      #1;
      check("t5_rst_serial_valid", serial_valid, 0);
      check("t5_rst_serial_out", serial_out, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 arst = 1'b0;

      // abort and in_valid together in IDLE: no capture.
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      abort       = 1'b1;
      parallel_in = 16'hFFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      @(negedge clk);
      check("t5_abort_in_ready", in_ready, 1);
      check("t5_abort_serial_valid", serial_valid, 0);
      check("t5_abort_busy", busy, 0);

      // Parity-sensitive word with a single set bit.
      wait_ready(10);
      push_frame(16'h0001, FB);
      send_word(16'h0001, 1'b1);
      for (int c = 1; c <= FB + 1; c++) begin
         @(negedge clk);
         check("t6_done", done, (c == FB + 1) ? 1 : 0);
         @(posedge clk);
         #1;
      end
      shift = 1'b0;
      wait_ready(10);

      @(negedge clk);
      check("remaining_bits", exp_bits.size(), 0);
      check("remaining_frames", exp_frames.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_readout.md
Name: piso_readout

Overview:
Parallel-in, serial-out readout shifter for one SRAM row word. It captures a COLS-bit word through a valid/ready handshake, then streams it MSB-first over a single-bit serial link. The downstream side paces each bit with a shift strobe, so the link is the transmit end of the serial-to-parallel column loader. The downstream receiver shifts in at the LSB, so MSB-first order reconstructs the word unchanged.

Parameters:
COLS, 16, word width in bits; legal range 2..256.
CNT_W, $clog2(COLS+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
arst  input  1  asynchronous reset, active-high.
in_valid  input  1  parallel word offered.
in_ready  output  1  block can accept a word.
parallel_in  input  COLS  word to transmit; sampled only on handshake.
abort  input  1  synchronous cancel of the current frame.
shift  input  1  downstream accepts the current serial bit this cycle.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out holds a valid bit.
busy  output  1  frame in progress (SHIFT or DONE).
done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (async, arst=1): state=IDLE, shift_reg=0, bit_cnt=0. Outputs: serial_out=0, serial_valid=0, busy=0, done=0, in_ready=1.
- FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registered state only, with no combinational path from inputs.
- IDLE:
  - in_ready=1.
  - On in_valid and no abort: shift_reg<=parallel_in, bit_cnt<=0, go to SHIFT.
- SHIFT:
  - serial_valid=1, serial_out=shift_reg[COLS-1], busy=1, in_ready=0.
  - On shift: shift_reg<={shift_reg[COLS-2:0],1'b0}, bit_cnt<=bit_cnt+1.
  - On shift with bit_cnt==COLS-1 (last bit): go to DONE.
  - Without shift: hold state, with no limit on stall length.
- DONE:
  - done=1, busy=1, serial_valid=0, serial_out=0, in_ready=0.
  - Next cycle unconditionally returns to IDLE.
- Latency: handshake at edge N puts the first bit valid in cycle N+1. With shift held high, the last bit is accepted at edge N+COLS. done is high in cycle N+COLS+1, and in_ready returns in cycle N+COLS+2.
- shift while serial_valid=0: ignored.
- in_valid while in_ready=0: ignored, word not captured. The upstream side must hold in_valid and parallel_in until in_ready.
- abort:
  - Takes effect at the next edge in any state: go to IDLE, bit_cnt<=0, no done pulse.
  - abort has priority over a simultaneous in_valid handshake and over shift.
- Reset mid-frame: frame dropped immediately, outputs forced to reset values, no done.
- bit_cnt never exceeds COLS (COLS+1 with the optional feature).

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - At capture, par<=^parallel_in (even parity) is stored.
  - After the COLS data bits, SHIFT presents one extra bit serial_out=par, serial_valid=1.
  - The frame is COLS+1 bits. The last-bit condition is bit_cnt==COLS, and all latencies grow by 1.
- Not defined: no par register, the frame is exactly COLS bits, and behaviour is as described above.

Test Plan:
- COLS=16, parallel_in=16'hA5C3 accepted at edge 0, shift held high -> serial_out in cycles 1..16 = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. done=1 only in cycle 17; in_ready=1 from cycle 18.
- Same word, shift high only on every third cycle -> identical bit sequence, each bit held stable until accepted, done after the 16th accepted shift, serial_valid never drops mid-frame.
- in_valid=1 with parallel_in=16'hFFFF during SHIFT of 16'h0000 -> stream stays all zeros, 16'hFFFF not captured, in_ready=0 throughout.
- abort asserted after 5 accepted bits of 16'hA5C3 -> IDLE next cycle, serial_valid=0, no done. A following word 16'h8001 streams 1,0..0,1 from bit 0.
- arst pulsed mid-frame at bit 9 -> all outputs at reset values immediately. abort and in_valid asserted together in IDLE -> no capture, in_ready stays 1.
- With PISO_PARITY_EN defined: 16'h0001 -> 17 bits, the 17th = 1, done in cycle 18. 16'hA5C3 -> 17th bit = 0. Loopback into the serial-to-parallel loader (COLS=16, macro undefined) then load -> parallel_out=16'hA5C3.
